// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode encoding and instruction geometry for the opcode/control interface
package cpu_pkg;
    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 32;
    typedef enum logic [OPCODE_W-1:0] {
        OP_END     = 4'h0,
        OP_SETC    = 4'h1,
        OP_DEC     = 4'h2,
        OP_BNZ     = 4'h3,
        OP_MATSET  = 4'h4,
        OP_MATXOR  = 4'h5,
        OP_ROTSBOX = 4'h6,
        OP_XORFL   = 4'h7,
        OP_XORKEY  = 4'h8,
        OP_MLSL    = 4'h9,
        OP_MSUB    = 4'hA,
        OP_MSHR    = 4'hB,
        OP_MMIX    = 4'hC
    } opcode_e;
endpackage

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches instructions from a synchronous ROM and offers them to decode
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin fetching at the current pc (IDLE only)
//   imem_addr / imem_rdata    ROM address (always equals pc) / read data, one cycle later
//   instr / instr_valid       registered instruction and valid towards decode
//   instr_ready               decode accepts instr (handshake = valid & ready)
//   branch_taken / _target    redirect pulse and destination from execute
//   pc                        address of the instruction being fetched or offered
//   halted                    high once an END instruction has been issued
module instr_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int IMEM_AW  = 8,
    parameter int INSTR_W  = cpu_pkg::INSTR_W,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [IMEM_AW-1:0] branch_target,
    output logic [IMEM_AW-1:0] pc,
    output logic               halted
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, HALT} fetch_state_e;

    fetch_state_e state;
    logic handshake;
    logic isEnd;

    assign imem_addr = pc;
    assign handshake = instr_valid && instr_ready;
    assign isEnd     = opcode_e'(instr[INSTR_W-1 -: OPCODE_W]) == OP_END;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= IMEM_AW'(RESET_PC);
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) state <= FETCH;
                // A redirect in FETCH just re-aims the read; the stale ROM word is never latched.
                FETCH: begin
                    if (branch_taken) pc <= branch_target;
                    else state <= LATCH;
                end
                LATCH: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end else begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                // An issued END beats a coincident branch; otherwise a branch overrides pc+1.
                ISSUE: begin
                    if (handshake && isEnd) begin
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                        state       <= HALT;
                    end else if (branch_taken || handshake) begin
                        pc          <= branch_taken ? branch_target : pc + IMEM_AW'(1);
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed checks of fetch, issue, backpressure, redirect, wrap, halt and reset
module tb_instr_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [7:0]  pc;
    logic        halted;
    logic [31:0] rom [256];
    int nAsserts = 0;
    int nFails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    instr_fetch_sequencer #(.IMEM_AW(8), .INSTR_W(32), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .halted(halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0]    = 32'h1000_0000;
        rom[1]    = 32'h0000_0000;
        rom[3]    = 32'h3000_0000;
        rom[5]    = 32'h0000_0000;
        rom[8'h20] = 32'h2000_0020;
        rom[8'hFF] = 32'h4000_00FF;
        step();
        step();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        rst = 1'b0;
        step();
        chk("idle_valid", 32'(instr_valid), 32'h0);
        // Test 1: two-instruction program ending in END, ready held high
        start = 1'b1; instr_ready = 1'b1;
        step();
        start = 1'b0;
        chk("t1_c1_valid", 32'(instr_valid), 32'h0);
        step();
        chk("t1_c2_pc", 32'(pc), 32'h0);
        step();
        chk("t1_c3_valid", 32'(instr_valid), 32'h1);
        chk("t1_c3_instr", instr, 32'h1000_0000);
        step();
        chk("t1_pc1", 32'(pc), 32'h1);
        chk("t1_addr1", 32'(imem_addr), 32'h1);
        chk("t1_valid_drop", 32'(instr_valid), 32'h0);
        step();
        step();
        chk("t1_end_valid", 32'(instr_valid), 32'h1);
        chk("t1_end_instr", instr, 32'h0);
        step();
        chk("t1_halted", 32'(halted), 32'h1);
        chk("t1_halt_valid", 32'(instr_valid), 32'h0);
        chk("t1_halt_pc", 32'(pc), 32'h1);
        start = 1'b1; branch_taken = 1'b1; branch_target = 8'h10;
        step();
        start = 1'b0; branch_taken = 1'b0;
        step();
        chk("halt_ignore_halted", 32'(halted), 32'h1);
        chk("halt_ignore_pc", 32'(pc), 32'h1);
        chk("halt_ignore_valid", 32'(instr_valid), 32'h0);
        rst = 1'b1; instr_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("rst2_halted", 32'(halted), 32'h0);
        chk("rst2_pc", 32'(pc), 32'h0);
        chk("rst2_instr", instr, 32'h0);
        // Test 2: backpressure holds instr/valid stable
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(instr_valid), 32'h1);
            chk("t2_hold_instr", instr, 32'h1000_0000);
            chk("t2_hold_pc", 32'(pc), 32'h0);
            step();
        end
        instr_ready = 1'b1;
        chk("t2_accept_valid", 32'(instr_valid), 32'h1);
        step();
        instr_ready = 1'b0;
        chk("t2_pc_once", 32'(pc), 32'h1);
        chk("t2_valid_drop", 32'(instr_valid), 32'h0);
        // Test 3: redirect in LATCH discards the fetched END at pc=1
        step();
        branch_taken = 1'b1; branch_target = 8'h20;
        step();
        branch_taken = 1'b0;
        chk("t3_pc", 32'(pc), 32'h20);
        chk("t3_addr", 32'(imem_addr), 32'h20);
        chk("t3_valid", 32'(instr_valid), 32'h0);
        step();
        step();
        chk("t3_valid_new", 32'(instr_valid), 32'h1);
        chk("t3_instr_new", instr, 32'h2000_0020);
        chk("t3_not_halted", 32'(halted), 32'h0);
        // Test 4: redirect in ISSUE without handshake, then with handshake
        branch_taken = 1'b1; branch_target = 8'h03;
        step();
        branch_taken = 1'b0;
        chk("t4_issue_redirect_pc", 32'(pc), 32'h3);
        chk("t4_issue_redirect_valid", 32'(instr_valid), 32'h0);
        step();
        step();
        chk("t4_rom3_valid", 32'(instr_valid), 32'h1);
        chk("t4_rom3_instr", instr, 32'h3000_0000);
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h05;
        step();
        instr_ready = 1'b0; branch_taken = 1'b0;
        chk("t4_hs_branch_pc", 32'(pc), 32'h5);
        chk("t4_hs_branch_valid", 32'(instr_valid), 32'h0);
        step();
        step();
        chk("t4_end_instr", instr, 32'h0);
        chk("t4_end_valid", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        step();
        instr_ready = 1'b0; branch_taken = 1'b0;
        chk("t4_end_wins_halted", 32'(halted), 32'h1);
        chk("t4_end_wins_pc", 32'(pc), 32'h5);
        // Test 5: pc wrap from 0xFF to 0x00
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        branch_taken = 1'b1; branch_target = 8'hFF;
        step();
        branch_taken = 1'b0;
        chk("t5_fetch_redirect_pc", 32'(pc), 32'hFF);
        step();
        step();
        chk("t5_ff_instr", instr, 32'h4000_00FF);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t5_wrap_pc", 32'(pc), 32'h0);
        chk("t5_wrap_addr", 32'(imem_addr), 32'h0);
        step();
        step();
        chk("t5_rom0_valid", 32'(instr_valid), 32'h1);
        chk("t5_rom0_instr", instr, 32'h1000_0000);
        // Test 6: reset mid-handshake
        instr_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; instr_ready = 1'b0;
        chk("t6_valid", 32'(instr_valid), 32'h0);
        chk("t6_pc", 32'(pc), 32'h0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_halted", 32'(halted), 32'h0);
        step();
        step();
        step();
        chk("t6_idle_valid", 32'(instr_valid), 32'h0);
        chk("t6_idle_pc", 32'(pc), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
